// File: rtl/v_wb_arb.sv
// Round-robin arbiter sharing one writeback port among N requesters with burst locking.
// Latency: 1 cycle (registered output stage); throughput 1 beat/cycle.
// Backpressure: out_ready low with out_valid high blocks all req_ready; out_* holds.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/last/data      per-requester beat (data slice i = [i*W +: W])
//   req_ready                per-requester accept strobe (onehot0)
//   out_valid/last/id/data   registered beat toward the writeback port
//   out_ready                writeback port accepts out_*
module v_wb_arb #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_last,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_id,
  output logic [W-1:0]         out_data,
  input  logic                 out_ready
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [IW-1:0]   r_ptr,   w_ptr_nxt;
  logic            r_out_valid;
  logic            r_out_last;
  logic [IW-1:0]   r_out_id;
  logic [W-1:0]    r_out_data;

  logic [IW-1:0]   w_scan_sel;
  logic            w_scan_hit;
  logic [IW-1:0]   w_sel;
  logic            w_sel_vld;
  logic            w_sel_last;
  logic [W-1:0]    w_sel_data;
  logic            w_can_acc;
  logic            w_acc;

  // (base + k) mod N without relying on IW overflow, so non-power-of-two N wraps correctly.
  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return s[IW-1:0];
  endfunction

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] x);
    logic [IW-1:0] r;
    if (int'(x) == N - 1) r = '0;
    else                  r = x + 1'b1;
    return r;
  endfunction

  // Scan from ptr upward; iterating downward lets the nearest requester win.
  always_comb begin
    w_scan_sel = '0;
    w_scan_hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_valid[rot_idx(r_ptr, k)]) begin
        w_scan_sel = rot_idx(r_ptr, k);
        w_scan_hit = 1'b1;
      end
    end
  end

  // While locked only the owner may be served; a missing owner beat is a bubble.
  assign w_sel      = (r_state == ST_LOCKED) ? r_owner : w_scan_sel;
  assign w_sel_vld  = (r_state == ST_LOCKED) ? req_valid[r_owner] : w_scan_hit;
  assign w_sel_last = req_last[w_sel];
  assign w_sel_data = req_data[int'(w_sel)*W +: W];

  assign w_can_acc  = !r_out_valid || out_ready;
  assign w_acc      = w_sel_vld && w_can_acc && !rst;

  always_comb begin
    req_ready = '0;
    if (w_acc) req_ready[w_sel] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (w_acc) begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel_last) begin
            w_ptr_nxt = inc_mod(w_sel);
          end else begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_sel;
          end
        end
        ST_LOCKED: begin
          if (w_sel_last) begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = inc_mod(r_owner);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Drain and load may coincide; a drain alone keeps payload fields unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
    end else if (w_acc) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_sel_last;
      r_out_id    <= w_sel;
      r_out_data  <= w_sel_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_id    = r_out_id;
  assign out_data  = r_out_data;

  a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));

  a_lock_owner_only : assert property (@(posedge clk) disable iff (rst)
    (r_state == ST_LOCKED) |-> ((req_ready & ~(N'(1) << r_owner)) == '0));

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=>
      (out_valid && $stable(out_data) && $stable(out_id) && $stable(out_last)));

endmodule

// File: tb/tb_v_wb_arb.sv
module tb_v_wb_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [31:0]  reqd [4];
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic         out_last;
  logic [1:0]   out_id;
  logic [31:0]  out_data;
  logic         out_ready;

  // N=3 instance for the non-power-of-two pointer wrap
  logic [2:0]   v3, l3, rr3;
  logic [95:0]  d3;
  logic         ov3, ol3;
  logic [1:0]   oid3;
  logic [31:0]  od3;
  logic         ordy3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];

  assign req_data = {reqd[3], reqd[2], reqd[1], reqd[0]};

  v_wb_arb #(.N(4), .W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_last(out_last), .out_id(out_id), .out_data(out_data),
    .out_ready(out_ready)
  );

  v_wb_arb #(.N(3), .W(32)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_last(l3), .req_data(d3),
    .req_ready(rr3),
    .out_valid(ov3), .out_last(ol3), .out_id(oid3), .out_data(od3),
    .out_ready(ordy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic last, input logic [31:0] data);
    beat_t b;
    b.id   = id;
    b.last = last;
    b.data = data;
    exp_q.push_back(b);
  endtask

  // One cycle of stimulus, applied at the falling edge; returns 1 time unit later.
  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                     input int idx, input logic [31:0] dval);
    @(negedge clk);
    req_valid = v;
    req_last  = l;
    out_ready = ordy;
    reqd[idx] = dval;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_last",  32'(out_last),  32'h0);
    chk("rst_out_id",    32'(out_id),    32'h0);
    chk("rst_out_data",  out_data,       32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    rst       = 1'b0;
    req_valid = 4'b0000;
    req_last  = 4'b0000;
  endtask

  // Scoreboard monitor: every transfer on the output port pops one expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected act id=%0d last=%0d data=%0h exp none",
                   out_id, out_last, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_id !== e.id || out_last !== e.last || out_data !== e.data) begin
            errors++;
            $display("FAIL beat act id=%0d last=%0d data=%0h exp id=%0d last=%0d data=%0h",
                     out_id, out_last, out_data, e.id, e.last, e.data);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) reqd[i] = '0;
    v3 = '0; l3 = '0; d3 = '0; ordy3 = 1'b1;

    // 1: all requesters, single-beat, rotation 0,1,2,3,0
    do_reset();
    for (int i = 1; i < 4; i++) reqd[i] = 32'h1000_0000 + 32'(i);
    push(2'd0, 1'b1, 32'h1000_0000);
    push(2'd1, 1'b1, 32'h1000_0001);
    push(2'd2, 1'b1, 32'h1000_0002);
    push(2'd3, 1'b1, 32'h1000_0003);
    push(2'd0, 1'b1, 32'h1000_0000);
    cyc(4'b1111, 4'b1111, 1'b1, 0, 32'h1000_0000);
    chk("t1_first_out_valid", 32'(out_valid), 32'h0);
    chk("t1_first_ready", 32'(req_ready), 32'h1);
    cyc(4'b1111, 4'b1111, 1'b1, 0, 32'h1000_0000);
    chk("t1_latency_out_valid", 32'(out_valid), 32'h1);
    chk("t1_second_ready", 32'(req_ready), 32'h2);
    cyc(4'b1111, 4'b1111, 1'b1, 0, 32'h1000_0000);
    cyc(4'b1111, 4'b1111, 1'b1, 0, 32'h1000_0000);
    cyc(4'b1111, 4'b1111, 1'b1, 0, 32'h1000_0000);
    chk("t1_wrap_ready", 32'(req_ready), 32'h1);
    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);

    // 2: req0 3-beat burst locks out req1
    do_reset();
    reqd[1] = 32'h2222_0001;
    push(2'd0, 1'b0, 32'h0000_00D0);
    push(2'd0, 1'b0, 32'h0000_00D1);
    push(2'd0, 1'b1, 32'h0000_00D2);
    push(2'd1, 1'b1, 32'h2222_0001);
    cyc(4'b0011, 4'b0010, 1'b1, 0, 32'h0000_00D0);
    chk("t2_beat0_ready", 32'(req_ready), 32'h1);
    cyc(4'b0011, 4'b0010, 1'b1, 0, 32'h0000_00D1);
    chk("t2_beat1_ready", 32'(req_ready), 32'h1);
    cyc(4'b0011, 4'b0011, 1'b1, 0, 32'h0000_00D2);
    chk("t2_beat2_ready", 32'(req_ready), 32'h1);
    cyc(4'b0010, 4'b0010, 1'b1, 0, 32'h0);
    chk("t2_req1_ready", 32'(req_ready), 32'h2);
    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);

    // 3: bubble inside req2 burst keeps the lock
    do_reset();
    reqd[3] = 32'h3333_000F;
    push(2'd2, 1'b0, 32'h0000_00AA);
    push(2'd2, 1'b1, 32'h0000_00BB);
    push(2'd3, 1'b1, 32'h3333_000F);
    cyc(4'b1100, 4'b1000, 1'b1, 2, 32'h0000_00AA);
    chk("t3_beatA_ready", 32'(req_ready), 32'h4);
    cyc(4'b1000, 4'b1000, 1'b1, 0, 32'h0);
    chk("t3_bubble1_ready", 32'(req_ready), 32'h0);
    cyc(4'b1000, 4'b1000, 1'b1, 0, 32'h0);
    chk("t3_bubble1_out_valid", 32'(out_valid), 32'h0);
    chk("t3_bubble2_ready", 32'(req_ready), 32'h0);
    cyc(4'b1100, 4'b1100, 1'b1, 2, 32'h0000_00BB);
    chk("t3_bubble2_out_valid", 32'(out_valid), 32'h0);
    chk("t3_beatB_ready", 32'(req_ready), 32'h4);
    cyc(4'b1000, 4'b1000, 1'b1, 0, 32'h0);
    chk("t3_req3_ready", 32'(req_ready), 32'h8);
    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);

    // 4: output stall holds data, then drain+load in one cycle
    do_reset();
    push(2'd0, 1'b1, 32'hDEAD_BEEF);
    push(2'd1, 1'b1, 32'hCAFE_0001);
    cyc(4'b0001, 4'b0001, 1'b1, 0, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0010, 4'b0010, 1'b0, 1, 32'hCAFE_0001);
      chk("t4_stall_ready", 32'(req_ready), 32'h0);
      chk("t4_stall_data", out_data, 32'hDEAD_BEEF);
    end
    cyc(4'b0010, 4'b0010, 1'b1, 1, 32'hCAFE_0001);
    chk("t4_release_ready", 32'(req_ready), 32'h2);
    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);
    chk("t4_loaded_data", out_data, 32'hCAFE_0001);

    // 5: reset in the middle of a locked req1 burst
    do_reset();
    push(2'd1, 1'b0, 32'h0000_0051);
    push(2'd1, 1'b0, 32'h0000_0052);
    push(2'd0, 1'b1, 32'h0000_00A0);
    push(2'd1, 1'b1, 32'h0000_0055);
    cyc(4'b0010, 4'b0000, 1'b1, 1, 32'h0000_0051);
    chk("t5_beat1_ready", 32'(req_ready), 32'h2);
    cyc(4'b0011, 4'b0000, 1'b1, 1, 32'h0000_0052);
    chk("t5_locked_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b0011; reqd[1] = 32'h0000_0055;
    #1;
    chk("t5_rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0011; req_last = 4'b0011; reqd[0] = 32'h0000_00A0;
    #1;
    chk("t5_after_rst_out_valid", 32'(out_valid), 32'h0);
    chk("t5_after_rst_ready", 32'(req_ready), 32'h1);
    cyc(4'b0010, 4'b0010, 1'b1, 0, 32'h0);
    chk("t5_req1_ready", 32'(req_ready), 32'h2);
    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);

    // 6: ptr wrap at N=4 (3->0) and N=3 (2->0)
    do_reset();
    push(2'd3, 1'b1, 32'h0000_0061);
    push(2'd3, 1'b1, 32'h0000_0062);
    cyc(4'b1000, 4'b1000, 1'b1, 3, 32'h0000_0061);
    v3 = 3'b100; l3 = 3'b100; d3[64 +: 32] = 32'h0000_0071;
    #1;
    chk("t6_first_ready", 32'(req_ready), 32'h8);
    chk("t6_n3_first_ready", 32'(rr3), 32'h4);
    cyc(4'b1000, 4'b1000, 1'b1, 3, 32'h0000_0062);
    v3 = 3'b111; l3 = 3'b111;
    #1;
    chk("t6_wrap_ready", 32'(req_ready), 32'h8);
    chk("t6_n3_wrap_ready", 32'(rr3), 32'h1);
    chk("t6_n3_out_id", 32'(oid3), 32'h2);
    chk("t6_n3_out_data", od3, 32'h0000_0071);
    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);
    v3 = 3'b000; l3 = 3'b000;
    #1;
    chk("t6_n3_next_valid", 32'(ov3), 32'h1);
    chk("t6_n3_next_id", 32'(oid3), 32'h0);

    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);
    cyc(4'b0000, 4'b0000, 1'b1, 0, 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
